// File: rtl/prio_enc_ctrl_pkg.sv
// Shared definitions for the registered priority encoder.
//   prio_enc_state_t : presentation FSM state (idle / presenting an index)
//   PE_DEFAULT_SEL_BITS : default index width for the encoder pair
package prio_enc_ctrl_pkg;

  localparam int PE_DEFAULT_SEL_BITS = 2;

  typedef enum logic {
    PE_IDLE    = 1'b0,
    PE_PRESENT = 1'b1
  } prio_enc_state_t;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: the inverse of the one-hot decoder `dec`.
// The lowest set index wins.
// Ports:
//   i_vec [N]           input vector, N = 2**N_SEL_BITS
//   o_idx [N_SEL_BITS]  binary index of the lowest set bit (0 when i_vec == 0)
//   o_any               at least one bit of i_vec is set
module prio_enc
  import prio_enc_ctrl_pkg::*;
#(
  parameter int N_SEL_BITS = PE_DEFAULT_SEL_BITS
) (
  input  logic [(1<<N_SEL_BITS)-1:0] i_vec,
  output logic [N_SEL_BITS-1:0]      o_idx,
  output logic                       o_any
);

  localparam int N = 1 << N_SEL_BITS;

  // Scan from the top down so the last hit (the lowest index) is kept.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = N_SEL_BITS'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_ctrl.sv
// Registered priority encoder with pending latches and a valid/ack handshake.
// Rising edges on the request lines set pending bits; the lowest-index
// unmasked pending bit is presented as a binary index.
//
// Handshake: o_valid/o_sel form a valid/ready pair with i_ack as ready. Once
// o_valid is high, o_sel is frozen until a cycle with i_ack=1; that edge
// retires the index (clears its pending bit) and drops o_valid. i_ack is
// ignored while o_valid is low. At least one idle cycle separates two
// presentations.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req[N]   request lines (0->1 transition is an event)
//   i_mask[N]  1 = line may be presented; masked lines still latch pending
//   i_ack      consumer accepts the presented index
//   i_clr      synchronous clear of pending bits and of any presentation
//   o_valid    o_sel holds a presented request
//   o_sel      binary index of the presented request
//   o_pending  registered pending vector
module prio_enc_ctrl
  import prio_enc_ctrl_pkg::*;
#(
  parameter int N_SEL_BITS = PE_DEFAULT_SEL_BITS
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [(1<<N_SEL_BITS)-1:0] i_req,
  input  logic [(1<<N_SEL_BITS)-1:0] i_mask,
  input  logic                       i_ack,
  input  logic                       i_clr,
  output logic                       o_valid,
  output logic [N_SEL_BITS-1:0]      o_sel,
  output logic [(1<<N_SEL_BITS)-1:0] o_pending
);

  localparam int N = 1 << N_SEL_BITS;

  prio_enc_state_t       state, state_n;
  logic [N_SEL_BITS-1:0] sel_q, sel_n;
  logic [N-1:0]          pend_q, pend_n;
  logic [N-1:0]          req_q;
  logic [N-1:0]          events;
  logic [N-1:0]          ack_clr;
  logic [N_SEL_BITS-1:0] cand_idx;
  logic                  cand_any;

  assign events = i_req & ~req_q;

  prio_enc #(
    .N_SEL_BITS(N_SEL_BITS)
  ) u_prio_enc (
    .i_vec(pend_q & i_mask),
    .o_idx(cand_idx),
    .o_any(cand_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= PE_IDLE;
      sel_q  <= '0;
      pend_q <= '0;
      req_q  <= '0;
    end else begin
      state  <= state_n;
      sel_q  <= sel_n;
      pend_q <= pend_n;
      req_q  <= i_req;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    ack_clr = '0;
    pend_n  = pend_q;

    unique case (state)
      PE_IDLE: begin
        // Selection looks at the registered pending vector, so a new event
        // is presented one edge after it is latched.
        if (cand_any) begin
          sel_n   = cand_idx;
          state_n = PE_PRESENT;
        end
      end
      PE_PRESENT: begin
        if (i_ack) begin
          ack_clr[sel_q] = 1'b1;
          state_n        = PE_IDLE;
        end
      end
      default: state_n = PE_IDLE;
    endcase

    // Clearing the acked bit happens before OR-ing events in, so a new
    // edge on the same line in the same cycle keeps it pending.
    pend_n = (pend_q & ~ack_clr) | events;

    // Clear overrides acks, selection and same-cycle events.
    if (i_clr) begin
      pend_n  = '0;
      state_n = PE_IDLE;
    end
  end

  assign o_valid   = (state == PE_PRESENT);
  assign o_sel     = sel_q;
  assign o_pending = pend_q;

endmodule

// File: doc/prio_enc_ctrl.md
Name: prio_enc_ctrl

Overview:
- Registered priority encoder: the inverse of the one-hot decoder `dec`. It turns a vector of request lines into one binary index.
- Latches rising edges on N request lines as pending bits. Presents the lowest-index unmasked pending request as a binary index and holds it stable under a valid/ack handshake.
- Sits between peripheral event lines and the core's trap/interrupt logic. The index feeds the cause-code path; `dec` re-expands it to one-hot where needed.

Parameters:
- N_SEL_BITS, 2, width of the output index; request count N = 2**N_SEL_BITS (legal range 1..5).

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_req  input  N  request lines, level signals; a 0->1 transition is an event.
- i_mask  input  N  1 = line enabled for presentation; masked lines still accumulate pending.
- i_ack  input  1  consumer accepts the presented index; meaningful only while o_valid=1.
- i_clr  input  1  synchronous clear of all pending bits and of any presentation.
- o_valid  output  1  o_sel holds a presented request.
- o_sel  output  N_SEL_BITS  binary index of the presented request.
- o_pending  output  N  registered pending vector.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_valid=0, o_sel=0, o_pending=0, request history register r_req_q=0.
- Edge detect:
  - r_req_q <= i_req every cycle.
  - Event vector e = i_req & ~r_req_q.
  - Each e bit sets its pending bit at that clock edge.
  - A line held high from reset produces one event in the first cycle after reset release.
- State IDLE (o_valid=0):
  - If (o_pending & i_mask) != 0, then o_sel <= lowest set index, o_valid <= 1, state -> PRESENT.
  - Otherwise remain in IDLE.
- State PRESENT (o_valid=1):
  - o_sel is frozen. It does not change if higher-priority requests arrive or the presented line becomes masked.
  - On i_ack=1: clear o_pending[o_sel], o_valid <= 0, state -> IDLE.
  - There is a mandatory one-cycle bubble between consecutive presentations.
- Latency:
  - Rising i_req sampled at edge k sets pending at edge k.
  - o_valid rises after edge k+1, provided the state was IDLE and the line is unmasked.
- Simultaneous events:
  - An ack-clear and a new event on the same bit in the same cycle: set wins, and pending stays 1.
  - i_clr has priority over everything except reset: pending=0, o_valid=0, state -> IDLE. Events in the same cycle are discarded.
- Pending bits are single-level. Repeated edges while pending do not count.
- Mask changes affect only the IDLE selection.
- i_ack while IDLE is ignored.
- Width: o_sel is an unsigned N_SEL_BITS field. The encoder output for an all-zero input is 0 and is never used.

Decomposition:
- Shared package (cotm32 comp pkg): state enum `prio_enc_state_t` {PE_IDLE, PE_PRESENT}.
- Sub-module `prio_enc`: parameter N_SEL_BITS; input i_vec[N]; outputs o_idx[N_SEL_BITS] and o_any.
  - Purely combinational, lowest index wins.
  - Instantiated once on (o_pending & i_mask).

Test Plan (N_SEL_BITS=2):
- Reset with i_req=4'b0100 held: after release, pending=4'b0100 at the first edge; o_valid=1 and o_sel=2 one edge later; ack -> o_valid=0 and pending=0.
- Simultaneous rise of i_req=4'b1010, mask=4'hF: present sel=1; ack; one bubble cycle; present sel=3; ack -> pending=0.
- While presenting sel=3, raise i_req[0]: o_sel remains 3 until ack; next presentation is sel=0.
- Mask=4'b1110, raise i_req[0]: pending=4'b0001, o_valid stays 0; set mask=4'hF -> o_valid=1 and sel=0 one edge later.
- Presenting sel=1: drop i_req[1], then re-raise it in the same cycle as i_ack -> pending[1] stays 1 and sel=1 is re-presented after the bubble.
- i_clr while o_valid=1 with pending=4'b1011 -> next edge o_valid=0 and pending=0; async i_rst_n pulse mid-cycle clears outputs immediately.
